branch_resolve: RTL and testbench

- EX-stage counterpart to the fetch stage's PC-select inputs.
- Records every taken-prediction fetch issues and retires each one when EX resolves the branch.
- Drives the redirect controls fetch consumes:
  - branch_undo + pc_not_taken on a mispredict.
  - pcr_take + pcr on a register jump.
- Then holds a pipeline flush for a fixed number of bubble cycles.

---
 rtl/branch_resolve.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_branch_resolve.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// EX-stage partner of the fetch PC-select logic. Every taken prediction made
// by fetch is recorded (its fall-through PC) in a small FIFO. When EX resolves
// the oldest prediction, the entry is retired. A wrong prediction redirects
// fetch to the recorded fall-through PC (branch_undo / pc_not_taken). A
// register-indirect jump redirects fetch to its target (pcr_take / pcr). Every
// redirect clears the queue and holds flush high for FLUSH_CYCLES non-stalled
// cycles, counting the redirect cycle itself.
//
// Optional build macro: BRANCH_STATS_EN adds the saturating statistics outputs
// stat_resolved and stat_mispredict.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               freezes queue, FSM and counters; suppresses pulses
//   pred_valid          push pred_pc_not_taken (fetch predicted taken)
//   pred_pc_not_taken   fall-through PC of the predicted branch
//   res_valid/res_taken resolution of the oldest predicted branch
//   jr_valid/jr_target  register-indirect jump executed in EX
//   branch_undo         1-cycle pulse, fetch restarts at pc_not_taken
//   pc_not_taken        restart PC (holds between redirects)
//   pcr_take            1-cycle pulse, fetch jumps to pcr
//   pcr                 jump target (holds between redirects)
//   flush               kill wrong-path instructions in IF/ID
//   pred_full           queue holds DEPTH entries
//   pred_count          queue occupancy
//   mispredict_err      sticky: resolution seen with an empty queue
//   stat_resolved       (BRANCH_STATS_EN) accepted resolutions, saturating
//   stat_mispredict     (BRANCH_STATS_EN) mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         pred_valid,
    input  logic [31:0]                  pred_pc_not_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic                         jr_valid,
    input  logic [31:0]                  jr_target,
    output logic                         branch_undo,
    output logic [31:0]                  pc_not_taken,
    output logic                         pcr_take,
    output logic [31:0]                  pcr,
    output logic                         flush,
    output logic                         pred_full,
    output logic [$clog2(DEPTH+1)-1:0]   pred_count,
    output logic                         mispredict_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]                  stat_resolved,
    output logic [15:0]                  stat_mispredict
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_CYCLES);
    localparam logic [FW-1:0] FL_ONE  = FW'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [31:0]     queue_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [FW-1:0]   flush_left_r;
    logic [FW-1:0]   flush_left_nxt_s;

    logic            undo_r;
    logic            take_r;
    logic [31:0]     pnt_r;
    logic [31:0]     pcr_r;
    logic            flush_r;
    logic            full_r;
    logic            err_r;

    logic            undo_nxt_s;
    logic            take_nxt_s;
    logic [31:0]     pnt_nxt_s;
    logic [31:0]     pcr_nxt_s;
    logic            flush_nxt_s;

    logic            run_s;
    logic            full_s;
    logic            has_entry_s;
    logic            accept_res_s;
    logic            mispredict_s;
    logic            pop_s;
    logic            jump_s;
    logic            redirect_s;
    logic            push_s;
    logic            err_set_s;
    logic [31:0]     head_s;

    // Event decode: what the queue and redirect logic should do this cycle.
    always_comb begin
        run_s        = (state_r == ST_RUN) && !stall;
        full_s       = (count_r == DEPTH_C);
        has_entry_s  = (count_r != {CW{1'b0}});
        head_s       = queue_r[rd_ptr_r];
        accept_res_s = run_s && res_valid && has_entry_s;
        mispredict_s = accept_res_s && !res_taken;
        pop_s        = accept_res_s && res_taken;
        // A mispredict outranks a same-cycle register jump.
        jump_s       = run_s && jr_valid && !mispredict_s;
        redirect_s   = mispredict_s || jump_s;
        // A correct resolution frees a slot, so a full queue may still push.
        push_s       = run_s && pred_valid && !redirect_s && (!full_s || pop_s);
        err_set_s    = run_s && res_valid && !has_entry_s;
    end

    // Occupancy next-value; any redirect empties the queue.
    always_comb begin
        count_nxt_s = count_r;
        if (redirect_s) begin
            count_nxt_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; the last non-stalled flush cycle returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!stall && (flush_left_r == FL_ONE)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // FSM output logic: next values of the registered redirect/flush outputs.
    always_comb begin
        undo_nxt_s       = mispredict_s;
        take_nxt_s       = jump_s;
        pnt_nxt_s        = pnt_r;
        pcr_nxt_s        = pcr_r;
        flush_left_nxt_s = flush_left_r;
        if (mispredict_s) begin
            pnt_nxt_s = head_s;
        end else begin
            pnt_nxt_s = pnt_r;
        end
        if (jump_s) begin
            pcr_nxt_s = jr_target;
        end else begin
            pcr_nxt_s = pcr_r;
        end
        // The redirect cycle counts as the first flush cycle.
        if (redirect_s) begin
            flush_left_nxt_s = FLUSH_C;
        end else if ((state_r == ST_FLUSH) && !stall) begin
            flush_left_nxt_s = flush_left_r - FL_ONE;
        end else begin
            flush_left_nxt_s = flush_left_r;
        end
        flush_nxt_s = (state_nxt_s == ST_FLUSH);
    end

    // Registered outputs and flush countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            undo_r       <= 1'b0;
            take_r       <= 1'b0;
            pnt_r        <= 32'h0000_0000;
            pcr_r        <= 32'h0000_0000;
            flush_r      <= 1'b0;
            full_r       <= 1'b0;
            err_r        <= 1'b0;
            flush_left_r <= {FW{1'b0}};
        end else begin
            undo_r       <= undo_nxt_s;
            take_r       <= take_nxt_s;
            pnt_r        <= pnt_nxt_s;
            pcr_r        <= pcr_nxt_s;
            flush_r      <= flush_nxt_s;
            full_r       <= (count_nxt_s == DEPTH_C);
            err_r        <= err_r | err_set_s;
            flush_left_r <= flush_left_nxt_s;
        end
    end

    // Prediction FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                queue_r[wr_ptr_r] <= pred_pc_not_taken;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_res_r;
    logic [15:0] stat_mis_r;

    // Saturating resolution / mispredict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_res_r <= 16'h0000;
            stat_mis_r <= 16'h0000;
        end else begin
            if (accept_res_s && (stat_res_r != 16'hFFFF)) begin
                stat_res_r <= stat_res_r + 16'h0001;
            end
            if (mispredict_s && (stat_mis_r != 16'hFFFF)) begin
                stat_mis_r <= stat_mis_r + 16'h0001;
            end
        end
    end

    assign stat_resolved   = stat_res_r;
    assign stat_mispredict = stat_mis_r;
`endif

    assign branch_undo    = undo_r;
    assign pcr_take       = take_r;
    assign pc_not_taken   = pnt_r;
    assign pcr            = pcr_r;
    assign flush          = flush_r;
    assign pred_full      = full_r;
    assign pred_count     = count_r;
    assign mispredict_err = err_r;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// Testbench for branch_resolve (DEPTH=4, FLUSH_CYCLES=2): a table of single-
// cycle vectors, hand-written stall / error / reset sequences, then random
// traffic compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pred_valid;
    logic [31:0] pred_pc_not_taken;
    logic        res_valid;
    logic        res_taken;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        branch_undo;
    logic [31:0] pc_not_taken;
    logic        pcr_take;
    logic [31:0] pcr;
    logic        flush;
    logic        pred_full;
    logic [2:0]  pred_count;
    logic        mispredict_err;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .pred_valid        (pred_valid),
        .pred_pc_not_taken (pred_pc_not_taken),
        .res_valid         (res_valid),
        .res_taken         (res_taken),
        .jr_valid          (jr_valid),
        .jr_target         (jr_target),
        .branch_undo       (branch_undo),
        .pc_not_taken      (pc_not_taken),
        .pcr_take          (pcr_take),
        .pcr               (pcr),
        .flush             (flush),
        .pred_full         (pred_full),
        .pred_count        (pred_count),
        .mispredict_err    (mispredict_err)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved     (stat_resolved),
        .stat_mispredict   (stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pv;
        logic [31:0] ppc;
        logic        rv;
        logic        rt;
        logic        jv;
        logic [31:0] jt;
        logic        e_undo;
        logic [31:0] e_pnt;
        logic        e_take;
        logic [31:0] e_pcr;
        logic        e_flush;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [31:0] mq[$];
    int          m_left;
    logic        m_undo;
    logic        m_take;
    logic [31:0] m_pnt;
    logic [31:0] m_pcr;
    logic        m_err;
    int          m_sres;
    int          m_smis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic undo, input logic [31:0] pnt,
                           input logic take, input logic [31:0] tgt, input logic fl,
                           input logic [2:0] cnt, input logic full, input logic err);
        chk({tag, ".branch_undo"},    32'(branch_undo),    32'(undo));
        chk({tag, ".pc_not_taken"},   pc_not_taken,        pnt);
        chk({tag, ".pcr_take"},       32'(pcr_take),       32'(take));
        chk({tag, ".pcr"},            pcr,                 tgt);
        chk({tag, ".flush"},          32'(flush),          32'(fl));
        chk({tag, ".pred_count"},     32'(pred_count),     32'(cnt));
        chk({tag, ".pred_full"},      32'(pred_full),      32'(full));
        chk({tag, ".mispredict_err"}, 32'(mispredict_err), 32'(err));
    endtask

    // Drive one cycle of inputs, clock it, then let outputs settle.
    task automatic cyc(input logic r, input logic s, input logic pv, input logic [31:0] ppc,
                       input logic rv, input logic rt, input logic jv, input logic [31:0] jt);
        rst = r; stall = s; pred_valid = pv; pred_pc_not_taken = ppc;
        res_valid = rv; res_taken = rt; jr_valid = jv; jr_target = jt;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic pv, input logic [31:0] ppc,
                               input logic rv, input logic rt, input logic jv, input logic [31:0] jt,
                               input logic eu, input logic [31:0] ep, input logic et,
                               input logic [31:0] ej, input logic ef, input logic [2:0] ec,
                               input logic efu, input logic ee);
        vec_t x;
        x.rst = r; x.stall = s; x.pv = pv; x.ppc = ppc; x.rv = rv; x.rt = rt; x.jv = jv; x.jt = jt;
        x.e_undo = eu; x.e_pnt = ep; x.e_take = et; x.e_pcr = ej; x.e_flush = ef;
        x.e_cnt = ec; x.e_full = efu; x.e_err = ee;
        return x;
    endfunction

    // Reference model: advance by one clock edge using the current inputs.
    task automatic model_edge();
        logic mis;
        logic popped;
        mis    = 1'b0;
        popped = 1'b0;
        if (rst) begin
            mq.delete();
            m_left = 0; m_undo = 1'b0; m_take = 1'b0;
            m_pnt = 32'h0; m_pcr = 32'h0; m_err = 1'b0;
            m_sres = 0; m_smis = 0;
        end else begin
            m_undo = 1'b0;
            m_take = 1'b0;
            if (stall) begin
                // everything frozen
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                if (res_valid) begin
                    if (mq.size() == 0) begin
                        m_err = 1'b1;
                    end else begin
                        if (m_sres < 65535) m_sres++;
                        if (res_taken) popped = 1'b1;
                        else mis = 1'b1;
                    end
                end
                if (mis) begin
                    if (m_smis < 65535) m_smis++;
                    m_undo = 1'b1;
                    m_pnt  = mq[0];
                    mq.delete();
                    m_left = FC;
                end else if (jr_valid) begin
                    m_take = 1'b1;
                    m_pcr  = jr_target;
                    mq.delete();
                    m_left = FC;
                end else begin
                    if (popped) void'(mq.pop_front());
                    if (pred_valid && (mq.size() < DEPTH)) mq.push_back(pred_pc_not_taken);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pred_valid = 1'b0; pred_pc_not_taken = 32'h0;
        res_valid = 1'b0; res_taken = 1'b0; jr_valid = 1'b0; jr_target = 32'h0;

        // ---------------- table-driven vectors ----------------
        //                 rst  stl  pv   ppc     rv   rt   jv   jt          undo pnt   take pcr      fl   cnt   full err
        tbl.push_back(v(1'b1,1'b0,1'b0,32'h00,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h14,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd1,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h24,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd2,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h34,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd3,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h44,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd4,1'b1,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h54,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd4,1'b1,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h64,1'b1,1'b1,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd4,1'b1,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd3,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd2,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd1,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h74,1'b1,1'b0,1'b1,32'h1000, 1'b1,32'h64,1'b0,32'h0000,1'b1,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h84,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h64,1'b0,32'h0000,1'b1,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h94,1'b1,1'b0,1'b0,32'h0000, 1'b0,32'h64,1'b0,32'h0000,1'b0,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b0,1'b0,1'b1,32'h1000, 1'b0,32'h64,1'b1,32'h1000,1'b1,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h64,1'b0,32'h1000,1'b1,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b0,32'h00,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h64,1'b0,32'h1000,1'b0,3'd0,1'b0,1'b0));
        tbl.push_back(v(1'b0,1'b0,1'b1,32'h14,1'b1,1'b1,1'b0,32'h0000, 1'b0,32'h64,1'b0,32'h1000,1'b0,3'd1,1'b0,1'b1));
        tbl.push_back(v(1'b1,1'b0,1'b0,32'h00,1'b0,1'b0,1'b0,32'h0000, 1'b0,32'h00,1'b0,32'h0000,1'b0,3'd0,1'b0,1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].stall, tbl[i].pv, tbl[i].ppc,
                tbl[i].rv, tbl[i].rt, tbl[i].jv, tbl[i].jt);
            chk_all($sformatf("vec%0d", i), tbl[i].e_undo, tbl[i].e_pnt, tbl[i].e_take,
                    tbl[i].e_pcr, tbl[i].e_flush, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_err);
        end

        // ---------------- mispredict held under stall ----------------
        cyc(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("stl_fill", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 32'h0);
            chk_all($sformatf("stl_hold%0d", i), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("stl_undo", 1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("stl_fl2", 1'b0, 32'h14, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("stl_end", 1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

        // ---------------- sticky error, reset during flush ----------------
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("err_set", 1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("err_hold", 1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 3'd1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("err_mis", 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("rst_flush", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("rst_after", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

        // ---------------- random traffic vs reference model ----------------
        for (int i = 0; i < 3000; i++) begin
            rst               = (i == 0) || ($urandom_range(0, 299) == 0);
            stall             = ($urandom_range(0, 4) == 0);
            pred_valid        = ($urandom_range(0, 1) == 1);
            pred_pc_not_taken = $urandom;
            res_valid         = ($urandom_range(0, 2) == 0);
            res_taken         = ($urandom_range(0, 3) != 0);
            jr_valid          = ($urandom_range(0, 11) == 0);
            jr_target         = $urandom;
            model_edge();
            @(posedge clk);
            #1;
            chk_all("rnd", m_undo, m_pnt, m_take, m_pcr, (m_left > 0), 3'(mq.size()),
                    (mq.size() == DEPTH), m_err);
`ifdef BRANCH_STATS_EN
            chk("rnd.stat_resolved",   32'(stat_resolved),   32'(m_sres));
            chk("rnd.stat_mispredict", 32'(stat_mispredict), 32'(m_smis));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
